// File: rtl/memory_pkg.sv
// Shared types and sizing for the boot-loadable program/data memory.
package memory_pkg;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/memory_ram16x8.sv
// Register-file RAM: async clear, one write port, one registered read port
// that returns the pre-write word when read and write hit the same edge.
module ram16x8
  import memory_pkg::*;
#(
  parameter int AW = memory_pkg::AW,
  parameter int DW = memory_pkg::DW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int NWORDS = 1 << AW;

  logic [DW-1:0] mem_q   [NWORDS];
  logic [DW-1:0] mem_d   [NWORDS];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Reads sample mem_q, so a same-edge write is not yet visible.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NWORDS; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
      rdata_q <= {DW{1'b0}};
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_unit.sv
// CPU-side memory with a boot loader: fills the array from a byte stream
// while holding the CPU in reset, then hands the bus to the CPU.
module memory_unit
  import memory_pkg::*;
#(
  parameter int AW = memory_pkg::AW,
  parameter int DW = memory_pkg::DW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          read,
  input  logic          write,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] memoryIn,
  output logic [DW-1:0] memoryOut,
  input  logic          load_en,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          load_done,
  output logic          cpu_hold
);

  localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};

  state_e        state_q;
  state_e        state_d;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;
  logic          xfer_s;
  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [DW-1:0] wdata_s;
  logic          re_s;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= BOOT;
      ptr_q   <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Boot ends either when the last word lands or when the host drops load_en.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: begin
        if (!load_en) begin
          state_d = RUN;
        end else if (xfer_s && (ptr_q == PTR_LAST)) begin
          state_d = RUN;
        end else begin
          state_d = BOOT;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    cpu_hold   = 1'b0;
    load_done  = 1'b0;
    load_ready = 1'b0;
    case (state_q)
      BOOT: begin
        cpu_hold   = 1'b1;
        load_ready = load_en;
      end
      RUN:     load_done = 1'b1;
      default: cpu_hold  = 1'b1;
    endcase
  end

  assign xfer_s = load_ready & load_valid;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer_s) begin
      ptr_d = ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Write-source mux: loader owns the port in BOOT, the CPU in RUN.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = {AW{1'b0}};
    wdata_s = {DW{1'b0}};
    re_s    = 1'b0;
    case (state_q)
      BOOT: begin
        we_s    = xfer_s;
        waddr_s = ptr_q;
        wdata_s = load_data;
      end
      RUN: begin
        we_s    = write;
        waddr_s = address;
        wdata_s = memoryIn;
        re_s    = read;
      end
      default: begin
        we_s = 1'b0;
        re_s = 1'b0;
      end
    endcase
  end

  ram16x8 #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk  (clk),
    .clr  (clr),
    .we   (we_s),
    .waddr(waddr_s),
    .wdata(wdata_s),
    .re   (re_s),
    .raddr(address),
    .rdata(memoryOut)
  );

endmodule
